// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and record types for the shared-multiplier arbiter
package mult_pkg;

    localparam int MUL_W    = 16;
    localparam int PROD_W   = 32;
    localparam int MUL_LAT  = 5;
    // Tags carry a fixed-width id; the top uses the low ID_W bits (ID_W must not exceed this).
    localparam int TAG_ID_W = 8;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } mul_tag_t;

    typedef struct packed {
        logic [TAG_ID_W-1:0] id;
        logic [PROD_W-1:0]   product;
    } rsp_entry_t;

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - synchronous FIFO with a registered head entry and no push-to-pop bypass
module result_fifo #(
    parameter int  DEPTH   = 8,
    parameter type entry_t = logic [7:0]
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_valid,
    input  entry_t push_data,
    input  logic   pop_ready,
    output logic   head_valid,
    output entry_t head_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    entry_t         mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           head_valid_q, head_valid_d;
    entry_t         head_data_q, head_data_d;
    logic           load, full;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full = (count_q == CW'(DEPTH));
    // Refill the head register whenever it is empty or being consumed.
    assign load = (count_q != '0) && (!head_valid_q || pop_ready);

    always_comb begin
        wr_ptr_d     = push_valid ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d     = load ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d      = count_q + CW'(push_valid) - CW'(load);
        head_valid_d = load | (head_valid_q & ~pop_ready);
        head_data_d  = load ? mem_q[rd_ptr_q] : head_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_valid) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(push_valid && full));

    assign head_valid = head_valid_q;
    assign head_data  = head_data_q;

endmodule

// File: rtl/wallace_mult.sv
// rtl/wallace_mult.sv - 5-stage pipelined 16x16 unsigned multiplier, tree-reduced partial products
module wallace_mult
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic [MUL_W-1:0]  a,
    input  logic [MUL_W-1:0]  b,
    output logic [PROD_W-1:0] p
);

    localparam int ROWS = MUL_W / 4;

    logic [MUL_W-1:0]  a_q, b_q;
    logic [PROD_W-1:0] grp_d [4];
    logic [PROD_W-1:0] grp_q [4];
    logic [PROD_W-1:0] pair_d [2];
    logic [PROD_W-1:0] pair_q [2];
    logic [PROD_W-1:0] sum_d, sum_q, p_q;

    // Four groups of partial-product rows, then a pairwise adder tree.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            grp_d[j] = '0;
            for (int i = 0; i < ROWS; i++) begin
                if (b_q[j*ROWS+i]) begin
                    grp_d[j] = grp_d[j] + (PROD_W'(a_q) << (j*ROWS+i));
                end
            end
        end
        pair_d[0] = grp_q[0] + grp_q[1];
        pair_d[1] = grp_q[2] + grp_q[3];
        sum_d     = pair_q[0] + pair_q[1];
    end

    always_ff @(posedge clk) begin
        a_q    <= a;
        b_q    <= b;
        grp_q  <= grp_d;
        pair_q <= pair_d;
        sum_q  <= sum_d;
        p_q    <= sum_q;
    end

    assign p = p_q;

endmodule

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin sharing of one pipelined multiplier with credit-protected result queue
module mult_share_arbiter
    import mult_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0][MUL_W-1:0]   req_a,
    input  logic [NUM_REQ-1:0][MUL_W-1:0]   req_b,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [ID_W-1:0]                 rsp_id,
    output logic [PROD_W-1:0]               rsp_p
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   ptr_q, ptr_d, winner, idx;
    logic              found, issue_ok, accept, push, pop, head_valid;
    mul_tag_t          tag_q [MUL_LAT];
    mul_tag_t          tag_d [MUL_LAT];
    logic [MUL_W-1:0]  mul_a, mul_b;
    logic [PROD_W-1:0] mul_p;
    rsp_entry_t        push_entry, head_entry;
    logic              unused_id_bits;

    // Search from ptr upward, wrapping; first valid requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // A pop in the same cycle does not free a credit for this cycle's issue.
    assign issue_ok = (cnt_q < CNT_W'(FIFO_DEPTH));
    assign accept   = found & issue_ok & ~rst;
    assign push     = tag_q[MUL_LAT-1].valid;
    assign pop      = head_valid & rsp_ready;

    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        ptr_d     = ptr_q;
        if (accept) begin
            req_ready[winner] = 1'b1;
            mul_a             = req_a[winner];
            mul_b             = req_b[winner];
            ptr_d             = ID_W'((int'(winner) + 1) % NUM_REQ);
        end

        tag_d[0] = '{valid: accept, id: TAG_ID_W'(winner)};
        for (int s = 1; s < MUL_LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end

        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        push_entry = '{id: tag_q[MUL_LAT-1].id, product: mul_p};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ptr_q <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
            tag_q <= tag_d;
        end
    end

    wallace_mult u_mult (
        .clk (clk),
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p)
    );

    result_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (rsp_entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push),
        .push_data  (push_entry),
        .pop_ready  (rsp_ready),
        .head_valid (head_valid),
        .head_data  (head_entry)
    );

    assign rsp_valid      = head_valid;
    assign rsp_id         = head_entry.id[ID_W-1:0];
    assign rsp_p          = head_entry.product;
    assign unused_id_bits = ^head_entry.id;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - randomized and directed bench against a queue-based reference model
module tb_mult_share_arbiter;

    localparam int NR    = 4;
    localparam int DEPTH = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NR-1:0]         req_valid;
    logic [NR-1:0]         req_ready;
    logic [NR-1:0][15:0]   req_a, req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic [31:0]           rsp_p;

    mult_share_arbiter #(.NUM_REQ(NR), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] p;
        int          acc;
    } exp_t;

    exp_t                q[$];
    int                  m_ptr = 0;
    int                  m_cnt = 0;
    int                  cyc   = 0;
    int                  checks = 0;
    int                  errors = 0;
    int                  obs_acc = 0;
    logic [NR-1:0][15:0] op_a, op_b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NR; i++) begin
            op_a[i] = 16'($urandom_range(0, 65535));
            op_b[i] = 16'($urandom_range(0, 65535));
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, check grant, advance the model.
    task automatic step(input logic [NR-1:0] v, input logic rr, input logic do_rst);
        logic          exp_rv;
        logic [NR-1:0] exp_rdy;
        int            w;
        exp_t          e;
        exp_rv = (q.size() != 0) && (q[0].acc + 6 <= cyc);
        check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        if (exp_rv) begin
            check("rsp_id", 64'(rsp_id), 64'(q[0].id));
            check("rsp_p", 64'(rsp_p), 64'(q[0].p));
        end
        req_valid = v;
        req_a     = op_a;
        req_b     = op_b;
        rsp_ready = rr;
        rst       = do_rst;
        #1;
        exp_rdy = '0;
        w       = -1;
        if (!do_rst && m_cnt < DEPTH) begin
            for (int k = 0; k < NR; k++) begin
                if (w < 0 && v[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
            end
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (|(req_valid & req_ready)) obs_acc++;
        @(posedge clk);
        cyc++;
        if (do_rst) begin
            q.delete();
            m_cnt = 0;
            m_ptr = 0;
        end else begin
            if (exp_rv && rr) begin
                void'(q.pop_front());
                m_cnt--;
            end
            if (w >= 0) begin
                e.id  = w;
                e.p   = 32'(op_a[w]) * 32'(op_b[w]);
                e.acc = cyc;
                q.push_back(e);
                m_ptr = (w + 1) % NR;
                m_cnt++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_id", 64'(rsp_id), 64'd0);
        check("reset_rsp_p", 64'(rsp_p), 64'd0);
        check("reset_cnt", 64'(dut.cnt_q), 64'd0);
        check("reset_ptr", 64'(dut.ptr_q), 64'd0);
        step(4'b1111, 1'b1, 1'b1);

        // single op: 3 * 5 from requester 0
        op_a[0] = 16'd3;
        op_b[0] = 16'd5;
        step(4'b0001, 1'b1, 1'b0);
        repeat (9) step(4'b0000, 1'b1, 1'b0);
        check("single_cnt_back_to_zero", 64'(dut.cnt_q), 64'd0);

        // full contention
        for (int n = 0; n < 20; n++) begin
            rand_ops();
            step(4'b1111, 1'b1, 1'b0);
        end
        repeat (10) step(4'b0000, 1'b1, 1'b0);

        // backpressure: exactly DEPTH accepts, then drain
        obs_acc = 0;
        for (int n = 0; n < 14; n++) begin
            rand_ops();
            step(4'b1111, 1'b0, 1'b0);
        end
        check("bp_accepts", 64'(obs_acc), 64'(DEPTH));
        for (int n = 0; n < 14; n++) begin
            rand_ops();
            step(4'b1111, 1'b1, 1'b0);
        end
        repeat (10) step(4'b0000, 1'b1, 1'b0);

        // arithmetic corners
        op_a = '0;
        op_b = '0;
        op_a[0] = 16'hFFFF; op_b[0] = 16'hFFFF;
        op_a[1] = 16'h0000; op_b[1] = 16'hABCD;
        op_a[2] = 16'h8000; op_b[2] = 16'h0002;
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        repeat (4) step(4'b0000, 1'b1, 1'b0);
        check("corner_ffff_sq", 64'(rsp_p), 64'hFFFE0001);
        step(4'b0000, 1'b1, 1'b0);
        check("corner_zero", 64'(rsp_p), 64'h0);
        step(4'b0000, 1'b1, 1'b0);
        check("corner_8000x2", 64'(rsp_p), 64'h00010000);
        repeat (6) step(4'b0000, 1'b1, 1'b0);

        // sparse fairness
        for (int n = 0; n < 12; n++) begin
            rand_ops();
            step(4'b1010, 1'b1, 1'b0);
        end
        repeat (10) step(4'b0000, 1'b1, 1'b0);

        // reset with results in flight and queued
        for (int n = 0; n < 5; n++) begin
            rand_ops();
            step(4'b1111, 1'b0, 1'b0);
        end
        repeat (2) step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b1);
        check("post_reset_ptr", 64'(dut.ptr_q), 64'd0);
        repeat (10) step(4'b0000, 1'b1, 1'b0);
        rand_ops();
        step(4'b1111, 1'b1, 1'b0);
        repeat (8) step(4'b0000, 1'b1, 1'b0);

        // randomized traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            rand_ops();
            step(NR'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
        end
        repeat (20) step(4'b0000, 1'b1, 1'b0);
        check("final_queue_empty", 64'(rsp_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
